// File: rtl/audio_pwm_dac_pkg.sv
// Shared sample-format constants and the sample-to-offset-binary helper
// used by the audio PWM DAC and its upstream synth.
package audio_pwm_dac_pkg;

  localparam int SAMPLE_WIDTH = 14;
  localparam logic [SAMPLE_WIDTH-1:0] OFFSET_MASK = 14'h2000;
  localparam int UNDERRUN_WIDTH = 16;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  // Attenuate by an arithmetic shift, then flip the sign bit to get offset binary.
  function automatic sample_t to_offset_binary(input sample_t s, input logic [2:0] vol);
    logic signed [SAMPLE_WIDTH-1:0] v;
    v = $signed(s) >>> vol;
    return sample_t'(v) ^ OFFSET_MASK;
  endfunction

endpackage

// File: rtl/audio_pwm_dac_if.sv
// Valid/ready sample stream between the synth (master) and the PWM DAC (slave).
interface audio_pwm_dac_if;
  import audio_pwm_dac_pkg::*;

  sample_t sample;
  logic    sample_valid;
  logic    sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);

endinterface

// File: rtl/audio_pwm_dac_sample_fifo.sv
// Synchronous sample FIFO with registered full/empty flags and entry count.
// The head entry is read straight from storage; no write-to-read bypass.
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == CW'(0));
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: buffers synth samples, releases one per PWM period and
// drives a 1-bit PWM output; back-pressure on the synth sets the sample rate.
module audio_pwm_dac
  import audio_pwm_dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CODE_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  audio_pwm_dac_if.slave            s_if,
  input  logic [2:0]                volume,
  input  logic                      mute,
  output logic [CODE_WIDTH-1:0]     dac_code,
  output logic                      pwm_out,
  output logic                      sample_tick,
  output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

  localparam logic [CODE_WIDTH-1:0]     CNT_MAX  = {CODE_WIDTH{1'b1}};
  localparam logic [CODE_WIDTH-1:0]     MID_CODE = {1'b1, {(CODE_WIDTH-1){1'b0}}};
  localparam logic [UNDERRUN_WIDTH-1:0] UNDER_MAX = {UNDERRUN_WIDTH{1'b1}};

  logic [CODE_WIDTH-1:0]     r_cnt;
  logic [CODE_WIDTH-1:0]     r_dac_code;
  logic                      r_pwm;
  logic                      r_tick;
  logic [UNDERRUN_WIDTH-1:0] r_underrun;

  logic [CODE_WIDTH-1:0]     w_cnt_next;
  logic [CODE_WIDTH-1:0]     w_code_next;
  logic [CODE_WIDTH-1:0]     w_conv_code;
  sample_t                   w_head;
  sample_t                   w_offset;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop_edge;
  logic                      w_pop;

  assign w_push     = s_if.sample_valid && s_if.sample_ready;
  assign w_pop_edge = (r_cnt == CNT_MAX);
  assign w_pop      = w_pop_edge && !w_empty;
  assign w_cnt_next = r_cnt + CODE_WIDTH'(1);

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (s_if.sample),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_offset = to_offset_binary(w_head, volume);

  // Duty code for the next period; held across periods that have no sample.
  always_comb begin
    w_conv_code = MID_CODE;
    w_code_next = r_dac_code;
    if (mute) begin
      w_conv_code = MID_CODE;
    end else begin
      w_conv_code = w_offset[SAMPLE_WIDTH-1 -: CODE_WIDTH];
    end
    if (w_pop) begin
      w_code_next = w_conv_code;
    end else begin
      w_code_next = r_dac_code;
    end
  end

  // Period counter, PWM comparator, period tick and underrun statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dac_code <= MID_CODE;
      r_pwm      <= 1'b0;
      r_tick     <= 1'b0;
      r_underrun <= '0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_dac_code <= w_code_next;
      r_pwm      <= (w_cnt_next < w_code_next);
      r_tick     <= (w_cnt_next == CODE_WIDTH'(0));
      if (w_pop_edge && w_empty && (r_underrun != UNDER_MAX)) begin
        r_underrun <= r_underrun + UNDERRUN_WIDTH'(1);
      end
    end
  end

  // Ready is the inverse of the registered full flag, so it is glitch-free.
  assign s_if.sample_ready = ~w_full;
  assign dac_code          = r_dac_code;
  assign pwm_out           = r_pwm;
  assign sample_tick       = r_tick;
  assign underrun_count    = r_underrun;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed self-checking bench for audio_pwm_dac with a 16-cycle PWM period
// and a 4-entry sample FIFO.
module tb_audio_pwm_dac;
  logic        clk;
  logic        rst;
  logic [2:0]  volume;
  logic        mute;
  logic [3:0]  dac_code;
  logic        pwm_out;
  logic        sample_tick;
  logic [15:0] underrun_count;
  logic [3:0]  m_cnt;
  int          checks;
  int          errors;

  audio_pwm_dac_if bus ();

  audio_pwm_dac #(.FIFO_DEPTH(4), .CODE_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_if           (bus),
    .volume         (volume),
    .mute           (mute),
    .dac_code       (dac_code),
    .pwm_out        (pwm_out),
    .sample_tick    (sample_tick),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference period counter: free-running from reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 4'd0;
    else     m_cnt <= m_cnt + 4'd1;
  end

  task automatic wait_cnt(input logic [3:0] k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != k && n < 40);
    checks++;
    if (m_cnt != k) begin
      errors++;
      $display("FAIL wait_cnt: counter=%0d required=%0d", m_cnt, k);
    end
  endtask

  task automatic push_sample(input logic [13:0] s);
    int n;
    n = 0;
    while (bus.sample_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: ready=%b required=1", bus.sample_ready);
    end
    bus.sample       = s;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    int highs;
    int ticks;
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (dac_code !== 4'd8) begin errors++; $display("FAIL rst_code: got %0d required 8", dac_code); end
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm: got %b required 0", pwm_out); end
    if (sample_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b required 0", sample_tick); end
    if (underrun_count !== 16'd0) begin errors++; $display("FAIL rst_underrun: got %0d required 0", underrun_count); end
    if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", bus.sample_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_cnt(4'd0);
    checks += 3;
    if (underrun_count !== 16'd1) begin errors++; $display("FAIL idle_underrun1: got %0d required 1", underrun_count); end
    if (sample_tick !== 1'b1) begin errors++; $display("FAIL idle_tick_at0: got %b required 1", sample_tick); end
    if (dac_code !== 4'd8) begin errors++; $display("FAIL idle_code: got %0d required 8", dac_code); end
    highs = 0;
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      if (pwm_out === 1'b1) highs++;
      if (sample_tick === 1'b1) ticks++;
      @(negedge clk);
    end
    checks += 3;
    if (highs != 8) begin errors++; $display("FAIL idle_pwm_highs: got %0d required 8", highs); end
    if (ticks != 1) begin errors++; $display("FAIL idle_ticks: got %0d required 1", ticks); end
    if (underrun_count !== 16'd2) begin errors++; $display("FAIL idle_underrun2: got %0d required 2", underrun_count); end
  endtask

  task automatic test_full_scale;
    int highs;
    volume = 3'd0;
    mute   = 1'b0;
    push_sample(14'h1FFF);
    wait_cnt(4'd0);
    highs = 0;
    checks++;
    if (dac_code !== 4'd15) begin errors++; $display("FAIL max_code: got %0d required 15", dac_code); end
    for (int i = 0; i < 16; i++) begin
      if (pwm_out === 1'b1) highs++;
      @(negedge clk);
    end
    checks++;
    if (highs != 15) begin errors++; $display("FAIL max_pwm_highs: got %0d required 15", highs); end
    push_sample(14'h2000);
    wait_cnt(4'd0);
    highs = 0;
    checks++;
    if (dac_code !== 4'd0) begin errors++; $display("FAIL min_code: got %0d required 0", dac_code); end
    for (int i = 0; i < 16; i++) begin
      if (pwm_out === 1'b1) highs++;
      @(negedge clk);
    end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL min_pwm_highs: got %0d required 0", highs); end
  endtask

  task automatic test_volume;
    int highs;
    // Volume is only sampled at the pop edge: queue at vol 1, pop at vol 0.
    volume = 3'd1;
    push_sample(14'h1000);
    wait_cnt(4'd14);
    volume = 3'd0;
    wait_cnt(4'd0);
    highs = 0;
    checks++;
    if (dac_code !== 4'd12) begin errors++; $display("FAIL vol0_code: got %0d required 12", dac_code); end
    for (int i = 0; i < 16; i++) begin
      if (pwm_out === 1'b1) highs++;
      @(negedge clk);
    end
    checks++;
    if (highs != 12) begin errors++; $display("FAIL vol0_pwm_highs: got %0d required 12", highs); end
    volume = 3'd1;
    push_sample(14'h1000);
    wait_cnt(4'd0);
    checks++;
    if (dac_code !== 4'd10) begin errors++; $display("FAIL vol1_code: got %0d required 10", dac_code); end
    push_sample(14'h3000);
    wait_cnt(4'd0);
    checks++;
    if (dac_code !== 4'd6) begin errors++; $display("FAIL vol1_neg_code: got %0d required 6", dac_code); end
    volume = 3'd0;
  endtask

  task automatic test_back_to_back;
    logic [13:0] samples [5];
    logic [3:0]  codes   [5];
    logic        rdy;
    logic [3:0]  c;
    logic [3:0]  fifth_cnt;
    logic [3:0]  code_at_fifth;
    logic [15:0] u0;
    int          idx;
    int          stalled;
    samples[0] = 14'h0400; codes[0] = 4'd9;
    samples[1] = 14'h3C00; codes[1] = 4'd7;
    samples[2] = 14'h1800; codes[2] = 4'd14;
    samples[3] = 14'h2400; codes[3] = 4'd1;
    samples[4] = 14'h0C00; codes[4] = 4'd11;
    idx = 0;
    stalled = 0;
    fifth_cnt = 4'hF;
    code_at_fifth = 4'hF;
    bus.sample = samples[0];
    bus.sample_valid = 1'b1;
    for (int n = 0; n < 40 && idx < 5; n++) begin
      rdy = bus.sample_ready;
      c = m_cnt;
      if (idx == 4 && rdy !== 1'b1) stalled++;
      if (idx == 4 && rdy === 1'b1) code_at_fifth = dac_code;
      @(negedge clk);
      if (rdy === 1'b1) begin
        if (idx == 4) fifth_cnt = c;
        idx++;
        if (idx < 5) bus.sample = samples[idx];
        else bus.sample_valid = 1'b0;
      end
    end
    bus.sample_valid = 1'b0;
    checks += 4;
    if (idx != 5) begin errors++; $display("FAIL b2b_accepted: got %0d required 5", idx); end
    if (stalled != 12) begin errors++; $display("FAIL b2b_stall_cycles: got %0d required 12", stalled); end
    if (fifth_cnt !== 4'd0) begin errors++; $display("FAIL b2b_fifth_edge: cnt %0d required 0", fifth_cnt); end
    if (code_at_fifth !== codes[0]) begin errors++; $display("FAIL b2b_pop0: got %0d required %0d", code_at_fifth, codes[0]); end
    for (int k = 1; k < 5; k++) begin
      wait_cnt(4'd0);
      checks++;
      if (dac_code !== codes[k]) begin errors++; $display("FAIL b2b_pop%0d: got %0d required %0d", k, dac_code, codes[k]); end
    end
    u0 = underrun_count;
    wait_cnt(4'd0);
    checks += 2;
    if (dac_code !== codes[4]) begin errors++; $display("FAIL b2b_hold: got %0d required %0d", dac_code, codes[4]); end
    if (underrun_count !== u0 + 16'd1) begin errors++; $display("FAIL b2b_underrun: got %0d required %0d", underrun_count, u0 + 16'd1); end
  endtask

  task automatic test_mute;
    mute = 1'b1;
    for (int i = 0; i < 4; i++) push_sample(14'h1FFF);
    checks++;
    if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL mute_full_ready: got %b required 0", bus.sample_ready); end
    wait_cnt(4'd0);
    checks += 2;
    if (dac_code !== 4'd8) begin errors++; $display("FAIL mute_code: got %0d required 8", dac_code); end
    if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL mute_popped_ready: got %b required 1", bus.sample_ready); end
  endtask

  task automatic test_reset_mid_period;
    mute = 1'b0;
    push_sample(14'h1FFF);
    wait_cnt(4'd0);
    checks++;
    if (dac_code !== 4'd15) begin errors++; $display("FAIL pre_rst_code: got %0d required 15", dac_code); end
    wait_cnt(4'd5);
    #1 rst = 1'b1;
    #1;
    checks += 5;
    if (dac_code !== 4'd8) begin errors++; $display("FAIL async_rst_code: got %0d required 8", dac_code); end
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL async_rst_pwm: got %b required 0", pwm_out); end
    if (sample_tick !== 1'b0) begin errors++; $display("FAIL async_rst_tick: got %b required 0", sample_tick); end
    if (underrun_count !== 16'd0) begin errors++; $display("FAIL async_rst_underrun: got %0d required 0", underrun_count); end
    if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b required 1", bus.sample_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cnt(4'd0);
    checks += 2;
    if (underrun_count !== 16'd1) begin errors++; $display("FAIL post_rst_underrun: got %0d required 1", underrun_count); end
    if (dac_code !== 4'd8) begin errors++; $display("FAIL post_rst_code: got %0d required 8", dac_code); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    volume = 3'd0;
    mute = 1'b0;
    bus.sample = 14'h0000;
    bus.sample_valid = 1'b0;
    test_reset();
    test_full_scale();
    test_volume();
    test_back_to_back();
    test_mute();
    test_reset_mid_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
